// File: rtl/fp_mul_iter.sv
// rtl/fp_mul_iter.sv - multi-cycle IEEE-754-style multiplier, radix-2 shift-add, RNE, flush-to-zero
// Special operands resolve at accept; normal operands iterate in MUL, then round once in NORM.
module fp_mul_iter #(
    parameter int  E_WIDTH = 8,
    parameter int  F_WIDTH = 23,
    localparam int W       = 1 + E_WIDTH + F_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] para1,
    input  logic [W-1:0] para2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);
    localparam int E_BIAS = 2 ** (E_WIDTH - 1) - 1;
    localparam int SW     = F_WIDTH + 1;
    localparam int PW     = 2 * SW;
    localparam int CW     = $clog2(F_WIDTH + 1);
    localparam int EW     = E_WIDTH + 2;

    localparam logic [EW-1:0] BIAS_X = EW'(E_BIAS);
    localparam logic [EW-1:0] E_MAX  = EW'(2 ** E_WIDTH - 1);
    localparam logic [W-1:0]  QNAN   = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(F_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t          state_q;
    logic            sign_q;
    logic [EW-1:0]   exp_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [SW-1:0]   mplier_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    out_q;
    logic            ovf_q;
    logic            unf_q;
    logic            inv_q;

    logic                sign_a, sign_b;
    logic [E_WIDTH-1:0]  exp_a, exp_b;
    logic [F_WIDTH-1:0]  frac_a, frac_b;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                sp_nan, sp_inf, sp_zero;

    assign {sign_a, exp_a, frac_a} = para1;
    assign {sign_b, exp_b, frac_b} = para2;

    assign a_zero  = ~|exp_a;
    assign b_zero  = ~|exp_b;
    assign a_nan   = (&exp_a) && (|frac_a);
    assign b_nan   = (&exp_b) && (|frac_b);
    assign a_inf   = (&exp_a) && ~|frac_a;
    assign b_inf   = (&exp_b) && ~|frac_b;
    assign sp_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign sp_inf  = a_inf || b_inf;
    assign sp_zero = a_zero || b_zero;

    // One shared adder: MUL accumulates through it, NORM folds in the final (hidden-bit) iteration.
    logic [PW-1:0]      prod_d;
    logic [PW-1:0]      shifted_d;
    logic               norm_d, guard_d, sticky_d, inc_d, carry_d;
    logic [SW:0]        rnd_d;
    logic [F_WIDTH-1:0] frac_d;
    logic [EW-1:0]      e_d;
    logic               ovf_d, unf_d;

    assign prod_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign norm_d    = prod_d[PW-1];
    assign shifted_d = norm_d ? prod_d : (prod_d << 1);
    assign guard_d   = shifted_d[F_WIDTH];
    assign sticky_d  = |shifted_d[F_WIDTH-1:0];
    assign inc_d     = guard_d && (sticky_d || shifted_d[F_WIDTH+1]);
    assign rnd_d     = {1'b0, shifted_d[PW-1 -: SW]} + {{SW{1'b0}}, inc_d};
    assign carry_d   = rnd_d[SW];
    assign frac_d    = carry_d ? rnd_d[F_WIDTH:1] : rnd_d[F_WIDTH-1:0];
    assign e_d       = exp_q + {{(EW-1){1'b0}}, norm_d} + {{(EW-1){1'b0}}, carry_d};
    assign ovf_d     = $signed(e_d) >= $signed(E_MAX);
    assign unf_d     = e_d[EW-1] || (e_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sign_q   <= sign_a ^ sign_b;
                    exp_q    <= {2'b00, exp_a} + {2'b00, exp_b} - BIAS_X;
                    acc_q    <= '0;
                    mcand_q  <= {{SW{1'b0}}, 1'b1, frac_a};
                    mplier_q <= {1'b1, frac_b};
                    cnt_q    <= CW'(F_WIDTH);
                    if (sp_nan) begin
                        out_q   <= QNAN;
                        {ovf_q, unf_q, inv_q} <= 3'b001;
                        state_q <= DONE;
                    end else if (sp_inf) begin
                        out_q   <= {sign_a ^ sign_b, {E_WIDTH{1'b1}}, {F_WIDTH{1'b0}}};
                        {ovf_q, unf_q, inv_q} <= 3'b000;
                        state_q <= DONE;
                    end else if (sp_zero) begin
                        out_q   <= {sign_a ^ sign_b, {(W-1){1'b0}}};
                        {ovf_q, unf_q, inv_q} <= 3'b000;
                        state_q <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                // F_WIDTH iterations here; the last one completes inside NORM via prod_d.
                MUL: begin
                    acc_q    <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= NORM;
                end
                NORM: begin
                    if (ovf_d) begin
                        out_q <= {sign_q, {E_WIDTH{1'b1}}, {F_WIDTH{1'b0}}};
                        {ovf_q, unf_q, inv_q} <= 3'b100;
                    end else if (unf_d) begin
                        out_q <= {sign_q, {(W-1){1'b0}}};
                        {ovf_q, unf_q, inv_q} <= 3'b010;
                    end else begin
                        out_q <= {sign_q, e_d[E_WIDTH-1:0], frac_d};
                        {ovf_q, unf_q, inv_q} <= 3'b000;
                    end
                    state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;
endmodule

// File: tb/tb_fp_mul_iter.sv
// tb/tb_fp_mul_iter.sv - scoreboard bench for fp_mul_iter against an integer-arithmetic reference
module tb_fp_mul_iter;
    localparam int F_W   = 23;
    localparam int LAT_N = F_W + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] para1, para2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        overflow, underflow, invalid;

    always #5 clk = ~clk;

    fp_mul_iter #(.E_WIDTH(8), .F_WIDTH(F_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .para1(para1), .para2(para2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_pend[$];
    int   acc_log[$];
    exp_t cur_exp;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic [2:0] flags, input int lat);
        exp_t r;
        r.res = res; r.flags = flags; r.lat = lat;
        return r;
    endfunction

    // Reference: exact integer product, then round-half-even by comparing remainder with half an ulp.
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        bit an, bn, ai, bi, az, bz;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        r = mk(32'h0, 3'b000, 1);
        if (an || bn || (ai && bz) || (bi && az)) begin
            r = mk(32'h7FC0_0000, 3'b001, 1);
        end else if (ai || bi) begin
            r = mk({s, 8'hFF, 23'h0}, 3'b000, 1);
        end else if (az || bz) begin
            r = mk({s, 31'h0}, 3'b000, 1);
        end else begin
            ma = 64'(a[22:0]) + 64'h80_0000;
            mb = 64'(b[22:0]) + 64'h80_0000;
            p  = ma * mb;
            e  = ea + eb - 127;
            if (p >= 64'h8000_0000_0000) begin sh = 24; e++; end
            else sh = 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
            if (e >= 255)    r = mk({s, 8'hFF, 23'h0}, 3'b100, LAT_N);
            else if (e <= 0) r = mk({s, 31'h0}, 3'b010, LAT_N);
            else             r = mk({s, 8'(e), q[22:0]}, 3'b000, LAT_N);
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_op();
        int r = $urandom_range(0, 19);
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        if (r < 13)       e = 8'($urandom_range(100, 154));
        else if (r < 16)  e = 8'($urandom_range(1, 254));
        else if (r == 16) e = 8'd0;
        else if (r == 17) begin e = 8'd0; f = '0; end
        else if (r == 18) begin e = 8'hFF; f = '0; end
        else              e = 8'hFF;
        if ($urandom_range(0, 7) == 0) f = '1;
        return {1'($urandom), e, f};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            sb.push_back(cur_exp);
            acc_pend.push_back(cyc + 1);
            acc_log.push_back(cyc + 1);
        end
    end

    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) chk(1'b0, "spurious_valid", 64'd1, 64'd0);
            else chk((cyc + 1 - acc_pend[0]) == sb[0].lat, "latency",
                     64'(cyc + 1 - acc_pend[0]), 64'(sb[0].lat));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            chk(out == sb[0].res, "result", 64'(out), 64'(sb[0].res));
            chk({overflow, underflow, invalid} == sb[0].flags, "flags",
                64'({overflow, underflow, invalid}), 64'(sb[0].flags));
            void'(sb.pop_front());
            void'(acc_pend.pop_front());
        end
        prev_valid <= out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n = 0;
        @(negedge clk);
        para1 = a; para2 = b; cur_exp = e; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(n < 300, "accept_timeout", 64'(n), 64'd300);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] da [16] = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3FFFFFFF,
                             32'h7F000000, 32'h80800000, 32'h7F800000, 32'hFF800000,
                             32'h00000001, 32'h7F000000, 32'h7F000000, 32'h00800000,
                             32'h7FC00001, 32'h80000000, 32'h3F800001, 32'h3F800003};
    logic [31:0] db [16] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3FFFFFFF,
                             32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000,
                             32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40400000};
    logic [31:0] dr [16] = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h407FFFFE,
                             32'h7F800000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                             32'h00000000, 32'h7F000000, 32'h7F800000, 32'h00800000,
                             32'h7FC00000, 32'h80000000, 32'h40400002, 32'h40400004};
    logic [2:0]  df [16] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000,
                             3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    int          dl [16] = '{25, 25, 25, 25, 25, 25, 1, 1, 1, 25, 25, 25, 1, 1, 25, 25};

    initial begin
        int n;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; para1 = '0; para2 = '0; out_ready = 1'b1;
        cur_exp = mk(32'h0, 3'b000, 0);
        repeat (3) @(negedge clk);
        chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        chk(out == 32'h0, "reset_out", 64'(out), 64'd0);
        chk({overflow, underflow, invalid} == 3'b000, "reset_flags",
            64'({overflow, underflow, invalid}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(da[i], db[i], mk(dr[i], df[i], dl[i]));
            wait_drain();
        end

        out_ready = 1'b0;
        issue(32'h3FC00000, 32'h40000000, mk(32'h40400000, 3'b000, LAT_N));
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk(out_valid == 1'b1, "hold_wait", 64'(out_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk(out_valid && out == 32'h40400000 && {overflow, underflow, invalid} == 3'b000,
                "hold_stable", 64'({out_valid, out, overflow, underflow, invalid}),
                64'({1'b1, 32'h40400000, 3'b000}));
            chk(in_ready == 1'b0, "hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        wait_drain();

        issue(32'hC0400000, 32'h3F000000, mk(32'hBFC00000, 3'b000, LAT_N));
        repeat (3) @(negedge clk);
        para1 = 32'h3F800000; para2 = 32'h3F800000;
        cur_exp = mk(32'hDEAD_BEEF, 3'b111, 0);
        in_valid = 1'b1;
        chk(in_ready == 1'b0, "busy_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk(sb.size() == 0 && !out_valid, "busy_pulse_ignored", 64'(sb.size()), 64'd0);

        issue(32'h3FC00000, 32'h40000000, mk(32'h40400000, 3'b000, LAT_N));
        issue(32'h3F800001, 32'h3F800001, mk(32'h3F800002, 3'b000, LAT_N));
        wait_drain();
        chk(acc_log[$] - acc_log[$-1] == F_W + 3, "issue_interval_normal",
            64'(acc_log[$] - acc_log[$-1]), 64'(F_W + 3));
        issue(32'h7F800000, 32'h00000000, mk(32'h7FC00000, 3'b001, 1));
        issue(32'hFF800000, 32'h40000000, mk(32'hFF800000, 3'b000, 1));
        wait_drain();
        chk(acc_log[$] - acc_log[$-1] == 2, "issue_interval_special",
            64'(acc_log[$] - acc_log[$-1]), 64'd2);

        issue(32'h3FC00000, 32'h40000000, mk(32'h40400000, 3'b000, LAT_N));
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        void'(acc_pend.pop_back());
        chk(in_ready == 1'b1, "abort_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "abort_out_valid", 64'(out_valid), 64'd0);
        chk(out == 32'h0, "abort_out", 64'(out), 64'd0);
        issue(32'h3FC00000, 32'h40000000, mk(32'h40400000, 3'b000, LAT_N));
        wait_drain();

        for (int i = 0; i < 60; i++) begin
            a = gen_op();
            b = gen_op();
            issue(a, b, ref_mul(a, b));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
